// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision multiply/divide datapath.
package fp_pkg;

    localparam int unsigned BUS_WIDTH = 32;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned EXP_BIAS  = 127;
    localparam int unsigned PROD_W    = 2 * MANT_W;
    localparam int unsigned ECALC_W   = 10;
    localparam int unsigned CNT_W     = 5;

    localparam logic [EXP_W-1:0]     EXP_MAX = 8'hFF;
    localparam logic [BUS_WIDTH-1:0] QNAN    = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        MULT,
        NORM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } fp_class_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Signed infinity / signed zero result words.
    function automatic logic [BUS_WIDTH-1:0] fp_inf(input logic s);
        return {s, EXP_MAX, FRAC_W'(0)};
    endfunction

    function automatic logic [BUS_WIDTH-1:0] fp_zero(input logic s);
        return {s, (BUS_WIDTH-1)'(0)};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Operand classifier (zero/normal/inf/NaN); denormals count as zero.
module fp_classify
    import fp_pkg::*;
(
    input  logic [BUS_WIDTH-1:0] data_i,
    output fp_class_e            cls_c_o
);

    fp32_t op;

    assign op = data_i;

    always_comb begin
        cls_c_o = NORMAL;
        if (op.exp == EXP_W'(0)) begin
            cls_c_o = ZERO;
        end else if (op.exp == EXP_MAX) begin
            cls_c_o = (op.frac == FRAC_W'(0)) ? INF : NAN;
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential single-precision multiplier: classify, 24-step shift-add, normalise.
// Flush-to-zero, truncating, all-ones canonical NaN.
module fp_mul_seq
    import fp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [BUS_WIDTH-1:0] data_iA,
    input  logic [BUS_WIDTH-1:0] data_iB,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    state_e                      state_q;
    fp32_t                       a_q;
    fp32_t                       b_q;
    logic [MANT_W-1:0]           ma_q;
    logic [MANT_W-1:0]           mb_q;
    logic [PROD_W-1:0]           p_q;
    logic signed [ECALC_W-1:0]   e_q;
    logic [CNT_W-1:0]            cnt_q;

    fp_class_e                   cls_a_c;
    fp_class_e                   cls_b_c;
    logic                        sign_c;
    logic                        special_c;
    logic [BUS_WIDTH-1:0]        special_res_c;
    logic [MANT_W:0]             sum_c;
    logic [PROD_W-1:0]           p_step_c;
    logic signed [ECALC_W-1:0]   e_sum_c;
    logic signed [ECALC_W-1:0]   e_norm_c;
    logic [FRAC_W-1:0]           mant_c;
    logic [BUS_WIDTH-1:0]        norm_res_c;

    fp_classify u_cls_a (
        .data_i  (a_q),
        .cls_c_o (cls_a_c)
    );

    fp_classify u_cls_b (
        .data_i  (b_q),
        .cls_c_o (cls_b_c)
    );

    // Special-operand result, in priority order.
    always_comb begin
        sign_c        = a_q.sign ^ b_q.sign;
        special_c     = 1'b1;
        special_res_c = QNAN;
        if (cls_a_c == NAN || cls_b_c == NAN) begin
            special_res_c = QNAN;
        end else if ((cls_a_c == INF && cls_b_c == ZERO) ||
                     (cls_a_c == ZERO && cls_b_c == INF)) begin
            special_res_c = QNAN;
        end else if (cls_a_c == INF || cls_b_c == INF) begin
            special_res_c = fp_inf(sign_c);
        end else if (cls_a_c == ZERO || cls_b_c == ZERO) begin
            special_res_c = fp_zero(sign_c);
        end else begin
            special_c = 1'b0;
        end
    end

    // One shift-add step: conditional add into the upper half, carry kept, then shift right.
    always_comb begin
        sum_c    = {1'b0, p_q[PROD_W-1:MANT_W]} + (mb_q[0] ? {1'b0, ma_q} : (MANT_W+1)'(0));
        p_step_c = {sum_c, p_q[MANT_W-1:1]};
    end

    // Biased exponent sum and truncating normalisation with range clamp.
    always_comb begin
        e_sum_c = $signed(ECALC_W'(a_q.exp)) + $signed(ECALC_W'(b_q.exp))
                - $signed(ECALC_W'(EXP_BIAS));
        if (p_q[PROD_W-1]) begin
            e_norm_c = e_q + ECALC_W'(1);
            mant_c   = p_q[PROD_W-2:MANT_W];
        end else begin
            e_norm_c = e_q;
            mant_c   = p_q[PROD_W-3:MANT_W-1];
        end
        if (e_norm_c >= $signed(ECALC_W'(255))) begin
            norm_res_c = fp_inf(sign_c);
        end else if (e_norm_c <= $signed(ECALC_W'(0))) begin
            norm_res_c = fp_zero(sign_c);
        end else begin
            norm_res_c = {sign_c, e_norm_c[EXP_W-1:0], mant_c};
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            p_q     <= '0;
            e_q     <= '0;
            cnt_q   <= '0;
            data_o  <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        a_q     <= data_iA;
                        b_q     <= data_iB;
                        busy_o  <= 1'b1;
                        state_q <= CLASSIFY;
                    end
                end
                CLASSIFY: begin
                    if (special_c) begin
                        data_o  <= special_res_c;
                        done_o  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ma_q    <= {1'b1, a_q.frac};
                        mb_q    <= {1'b1, b_q.frac};
                        p_q     <= '0;
                        cnt_q   <= '0;
                        e_q     <= e_sum_c;
                        state_q <= MULT;
                    end
                end
                MULT: begin
                    p_q  <= p_step_c;
                    mb_q <= mb_q >> 1;
                    if (cnt_q == CNT_W'(MANT_W - 1)) begin
                        state_q <= NORM;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                NORM: begin
                    data_o  <= norm_res_c;
                    done_o  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Bench for fp_mul_seq: directed cases plus randomized operands against a reference model.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] data_iA;
    logic [31:0] data_iB;
    logic [31:0] data_o;
    logic        busy_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mul_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .data_iA (data_iA),
        .data_iB (data_iB),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: real-valued product rules, mantissa product by plain integer multiply.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [22:0] fa, fb, mant;
        logic [47:0] prod;
        bit          az, ai, an, bz, bi, bn;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        fa = a[22:0];         fb = b[22:0];
        az = (ea == 0); ai = (ea == 255) && (fa == 0); an = (ea == 255) && (fa != 0);
        bz = (eb == 0); bi = (eb == 255) && (fb == 0); bn = (eb == 255) && (fb != 0);
        if (an || bn) return 32'hFFFF_FFFF;
        if ((ai && bz) || (bi && az)) return 32'hFFFF_FFFF;
        if (ai || bi) return {s, 8'hFF, 23'd0};
        if (az || bz) return {s, 31'd0};
        prod = 48'({1'b1, fa}) * 48'({1'b1, fb});
        e = ea + eb - 127;
        if (prod[47]) begin
            mant = prod[46:24];
            e++;
        end else begin
            mant = prod[45:23];
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), mant};
    endfunction

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) ||
               (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    // One transaction; edges counted from the accepting edge. Optional ignored start mid-run.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit inject);
        int n;
        int exp_lat;
        exp_lat = is_special(a, b) ? 1 : 26;
        @(negedge clk);
        data_iA = a; data_iB = b; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        data_iA = $urandom; data_iB = $urandom;
        chk({tag, "_busy_rise"}, 32'(busy_o), 32'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (inject && n == 5) begin
                start_i = 1'b1; data_iA = 32'h3F80_0000; data_iB = 32'h3F80_0000;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) break;
        end
        start_i = 1'b0;
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_data"}, data_o, exp);
        chk({tag, "_busy_at_done"}, 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
        chk({tag, "_busy_fall"}, 32'(busy_o), 32'd0);
        chk({tag, "_data_hold"}, data_o, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        rst_n = 1'b0; start_i = 1'b0; data_iA = '0; data_iB = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", data_o, 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);
        run_op("mul_1p5sq",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
        run_op("mul_neg",     32'hBF80_0000, 32'h4000_0000, 32'hC000_0000, 1'b0);
        run_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("nan_x_one",   32'h7FC0_0000, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("ninf_x_2",    32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        run_op("nzero_x_3",   32'h8000_0000, 32'h4040_0000, 32'h8000_0000, 1'b0);
        run_op("denorm_x_2",  32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("overflow",    32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 1'b0);
        run_op("underflow",   32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 1'b0);
        run_op("start_ignored", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b1);

        // Reset in the middle of the multiply loop.
        @(negedge clk);
        data_iA = 32'h3FC0_0000; data_iB = 32'h3FC0_0000; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_data", data_o, 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_op("after_rst_2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1'b0);

        // Randomized operands, exponent biased toward the interesting ends.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra[30:23] = 8'(($urandom_range(0, 1) == 0) ? 0 : 255);
                1: rb[30:23] = 8'($urandom_range(0, 3));
                2: begin ra[30:23] = 8'($urandom_range(100, 160)); rb[30:23] = 8'($urandom_range(100, 160)); end
                3: begin ra[30:23] = 8'($urandom_range(1, 70)); rb[30:23] = 8'($urandom_range(1, 70)); end
                4: begin ra[30:23] = 8'($urandom_range(190, 254)); rb[30:23] = 8'($urandom_range(120, 160)); end
                default: ;
            endcase
            run_op("random", ra, rb, ref_mul(ra, rb), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
